// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, packs LSB-first dibits into bytes, flags frame errors.
// Optional RMII_RX_FCS_CHECK_EN adds a CRC-32 residue check at end of frame.
module rmii_rx_deframer #(
  parameter int MAX_BYTES    = 1536,
  parameter int LEN_W        = 11,
  parameter int PREAMBLE_MIN = 4
) (
  input  logic             clk_rmii,
  input  logic             rst_ni,
  input  logic [1:0]       rxd_i,
  input  logic             crs_dv_i,
  input  logic             rx_er_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_sof_o,
  output logic             rx_eof_o,
  output logic             rx_err_o,
  output logic [LEN_W-1:0] rx_len_o,
  output logic             rx_active_o,
  output logic [15:0]      rx_bad_cnt_o
);

  typedef enum logic [1:0] {DROP, IDLE, PRE, DATA} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rxd_s1_q, rxd_s2_q;
  logic             crs_s1_q, crs_s2_q, er_s1_q;
  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [LEN_W-1:0] bcnt_q, bcnt_d;
  logic             err_acc_q, err_acc_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      bad_q, bad_d;
  logic             push_pend, push_cur, done, fcs_bad;
  logic [7:0]       acc_t, byte_v;
  logic [1:0]       cnt_t;

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  // Register shifts right (reflected); residue is compared in MSB-first bit order.
  assign fcs_bad = (bcnt_q != '0) && (bitrev(crc_q) != 32'hC704DD7B);

  always_ff @(posedge clk_rmii or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 32'hFFFFFFFF;
    else         crc_q <= crc_d;
  end
`else
  assign fcs_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bcnt_d    = bcnt_q;
    err_acc_d = err_acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = err_q;
    len_d     = len_q;
    bad_d     = bad_q;
    push_pend = 1'b0;
    push_cur  = 1'b0;
    done      = 1'b0;
    byte_v    = '0;
`ifdef RMII_RX_FCS_CHECK_EN
    crc_d     = crc_q;
`endif
    case (state_q)
      DROP: if (!crs_s1_q && !crs_s2_q) state_d = IDLE;
      IDLE: if (crs_s1_q) begin
        if (rxd_s1_q == 2'b01) begin
          state_d   = PRE;
          pre_cnt_d = 8'd1;
        end else if (rxd_s1_q != 2'b00) begin
          state_d = DROP;
        end
      end
      PRE: begin
        if (crs_s1_q && rxd_s1_q == 2'b01) begin
          if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (crs_s1_q && rxd_s1_q == 2'b11 && pre_cnt_q >= 8'(PREAMBLE_MIN)) begin
          state_d   = DATA;
          bcnt_d    = '0;
          err_acc_d = 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
          crc_d     = 32'hFFFFFFFF;
`endif
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        err_acc_d = err_acc_q | er_s1_q;
        // A low-CRS dibit waits in s2; a second low sample ends the frame and discards it.
        if (!crs_s1_q && !crs_s2_q) begin
          state_d = IDLE;
          eof_d   = 1'b1;
          len_d   = bcnt_q;
          err_d   = err_acc_d | (dcnt_q != 2'd0) | fcs_bad;
        end else if (crs_s1_q) begin
          push_pend = !crs_s2_q;
          push_cur  = 1'b1;
        end
      end
      default: state_d = DROP;
    endcase

    acc_t = acc_q;
    cnt_t = dcnt_q;
    if (push_pend) begin
      acc_t = {rxd_s2_q, acc_t[7:2]};
      if (cnt_t == 2'd3) begin
        done   = 1'b1;
        byte_v = acc_t;
      end
      cnt_t = cnt_t + 2'd1;
    end
    if (push_cur) begin
      acc_t = {rxd_s1_q, acc_t[7:2]};
      if (cnt_t == 2'd3) begin
        done   = 1'b1;
        byte_v = acc_t;
      end
      cnt_t = cnt_t + 2'd1;
    end
    acc_d  = acc_t;
    dcnt_d = (state_q == DATA) ? cnt_t : 2'd0;

    if (done) begin
      if (bcnt_q == LEN_W'(MAX_BYTES)) begin
        state_d = DROP;
        eof_d   = 1'b1;
        err_d   = 1'b1;
        len_d   = bcnt_q;
      end else begin
        valid_d = 1'b1;
        data_d  = byte_v;
        sof_d   = (bcnt_q == '0);
        bcnt_d  = bcnt_q + LEN_W'(1);
`ifdef RMII_RX_FCS_CHECK_EN
        crc_d   = crc_byte(crc_q, byte_v);
`endif
      end
    end

    if (eof_d && err_d && bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
  end

  always_ff @(posedge clk_rmii or negedge rst_ni) begin
    if (!rst_ni) begin
      // CRS history resets high so a carrier already present at release keeps us in DROP.
      rxd_s1_q  <= 2'b00;
      rxd_s2_q  <= 2'b00;
      crs_s1_q  <= 1'b1;
      crs_s2_q  <= 1'b1;
      er_s1_q   <= 1'b0;
      state_q   <= DROP;
      pre_cnt_q <= '0;
      acc_q     <= '0;
      dcnt_q    <= '0;
      bcnt_q    <= '0;
      err_acc_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      bad_q     <= '0;
    end else begin
      rxd_s1_q  <= rxd_i;
      rxd_s2_q  <= rxd_s1_q;
      crs_s1_q  <= crs_dv_i;
      crs_s2_q  <= crs_s1_q;
      er_s1_q   <= rx_er_i;
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      acc_q     <= acc_d;
      dcnt_q    <= dcnt_d;
      bcnt_q    <= bcnt_d;
      err_acc_q <= err_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
      len_q     <= len_d;
      bad_q     <= bad_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign rx_sof_o     = sof_q;
  assign rx_eof_o     = eof_q;
  assign rx_err_o     = err_q;
  assign rx_len_o     = len_q;
  assign rx_active_o  = (state_q == DATA);
  assign rx_bad_cnt_o = bad_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer: table of frames plus a mid-frame reset sequence.
module tb_rmii_rx_deframer;

`ifdef RMII_RX_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic        clk_rmii = 1'b0;
  logic        rst_ni;
  logic [1:0]  rxd_i;
  logic        crs_dv_i;
  logic        rx_er_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, rx_sof_o, rx_eof_o, rx_err_o, rx_active_o;
  logic [10:0] rx_len_o;
  logic [15:0] rx_bad_cnt_o;

  rmii_rx_deframer dut (
    .clk_rmii    (clk_rmii),
    .rst_ni      (rst_ni),
    .rxd_i       (rxd_i),
    .crs_dv_i    (crs_dv_i),
    .rx_er_i     (rx_er_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_sof_o    (rx_sof_o),
    .rx_eof_o    (rx_eof_o),
    .rx_err_o    (rx_err_o),
    .rx_len_o    (rx_len_o),
    .rx_active_o (rx_active_o),
    .rx_bad_cnt_o(rx_bad_cnt_o)
  );

  always #10 clk_rmii = ~clk_rmii;

  typedef struct {
    string name;
    int    nbytes;
    int    pre;
    int    flip;
    int    er_byte;
    int    extra;
    bit    toggle;
    int    exp_strobes;
    int    exp_len;
    bit    exp_err;
    int    exp_eofs;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] fr[1600];
  logic [7:0] got[$];
  int         sof_cnt, sof_bad, eof_cnt, eof_len, eof_err;
  int         nchecks = 0, nerr = 0, exp_bad = 0;

  always @(negedge clk_rmii) begin
    if (rx_valid_o) begin
      got.push_back(rx_data_o);
      if (rx_sof_o) begin
        sof_cnt++;
        if (got.size() != 1) sof_bad++;
      end
    end else if (rx_sof_o) begin
      sof_bad++;
    end
    if (rx_eof_o) begin
      eof_cnt++;
      eof_len = int'(rx_len_o);
      eof_err = int'(rx_err_o);
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    nchecks++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    sof_cnt = 0; sof_bad = 0; eof_cnt = 0; eof_len = -1; eof_err = -1;
  endtask

  task automatic drive(input logic [1:0] d, input logic crs, input logic er);
    @(posedge clk_rmii);
    #1;
    rxd_i = d; crs_dv_i = crs; rx_er_i = er;
  endtask

  // Payload pattern followed by a valid Ethernet FCS (reflected CRC-32, complemented, LSB byte first).
  task automatic build(input int n, input int flip);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      if (n >= 4 && i >= n - 4) fr[i] = 8'(~c >> (8 * (i - (n - 4))));
      else begin
        fr[i] = 8'(i * 13 + 5);
        for (int b = 0; b < 8; b++)
          c = (c[0] ^ fr[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    if (flip >= 0) fr[flip][0] = ~fr[flip][0];
  endtask

  task automatic preamble(input int pre);
    for (int i = 0; i < pre; i++) drive(2'b01, 1'b1, 1'b0);
    drive(2'b11, 1'b1, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int mism;
    clear_mon();
    build(v.nbytes, v.flip);
    preamble(v.pre);
    for (int i = 0; i < v.nbytes; i++)
      for (int k = 0; k < 4; k++)
        drive(fr[i][2*k +: 2], !(v.toggle && i == v.nbytes - 1 && (k == 0 || k == 2)),
              (i == v.er_byte && k == 0));
    for (int i = 0; i < v.extra; i++) drive(2'b10, 1'b1, 1'b0);
    gap(10);
    mism = 0;
    for (int i = 0; i < got.size() && i < v.exp_strobes; i++)
      if (got[i] != fr[i]) mism++;
    if (v.exp_eofs != 0 && v.exp_err) exp_bad++;
    chk({v.name, " strobes"}, got.size(), v.exp_strobes);
    chk({v.name, " data"}, mism, 0);
    chk({v.name, " sof"}, sof_cnt + 100 * sof_bad, (v.exp_strobes > 0) ? 1 : 0);
    chk({v.name, " eofs"}, eof_cnt, v.exp_eofs);
    if (v.exp_eofs != 0) begin
      chk({v.name, " len"}, eof_len, v.exp_len);
      chk({v.name, " err"}, eof_err, int'(v.exp_err));
    end
    chk({v.name, " bad_cnt"}, int'(rx_bad_cnt_o), exp_bad);
  endtask

  initial begin
    vecs[0] = '{"good64",   64,   28, -1, -1, 0, 1'b1, 64,   64,   1'b0,   1};
    vecs[1] = '{"flip64",   64,   28, 20, -1, 0, 1'b1, 64,   64,   FCS_EN, 1};
    vecs[2] = '{"rxer64",   64,   28, -1, 10, 0, 1'b0, 64,   64,   1'b1,   1};
    vecs[3] = '{"align64",  64,   28, -1, -1, 1, 1'b0, 64,   64,   1'b1,   1};
    vecs[4] = '{"ovf1600",  1600, 28, -1, -1, 0, 1'b0, 1536, 1536, 1'b1,   1};
    vecs[5] = '{"max1536",  1536, 28, -1, -1, 0, 1'b1, 1536, 1536, 1'b0,   1};
    vecs[6] = '{"zero",     0,    28, -1, -1, 0, 1'b0, 0,    0,    1'b0,   1};
    vecs[7] = '{"shortpre", 16,   3,  -1, -1, 0, 1'b0, 0,    0,    1'b0,   0};
    vecs[8] = '{"minpre",   64,   4,  -1, -1, 0, 1'b1, 64,   64,   1'b0,   1};

    rst_ni = 1'b0; rxd_i = 2'b00; crs_dv_i = 1'b0; rx_er_i = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk_rmii);
    #1;
    chk("reset ctl", int'({rx_valid_o, rx_sof_o, rx_eof_o, rx_err_o, rx_active_o}), 0);
    chk("reset dat", int'({rx_data_o, rx_len_o}), 0);
    chk("reset bad", int'(rx_bad_cnt_o), 0);
    rst_ni = 1'b1;
    gap(5);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame while the carrier stays up.
    clear_mon();
    build(64, -1);
    preamble(28);
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) begin
        drive(fr[i][2*k +: 2], 1'b1, 1'b0);
        if (i == 30 && k == 0) begin
          chk("active mid", int'(rx_active_o), 1);
          rst_ni = 1'b0;
        end
        if (i == 31 && k == 0) begin
          chk("rst mid ctl", int'({rx_valid_o, rx_sof_o, rx_eof_o, rx_err_o, rx_active_o}), 0);
          chk("rst mid bad", int'(rx_bad_cnt_o), 0);
          rst_ni = 1'b1;
          exp_bad = 0;
          clear_mon();
        end
      end
    gap(10);
    chk("post-rst strobes", got.size(), 0);
    chk("post-rst eofs", eof_cnt, 0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
